// File: rtl/branch_predictor_table.sv
// branch_predictor_table
//   PC-indexed branch direction predictor built from a table of saturating
//   counters. Bimodal when HIST_BITS == 0, gshare (index XOR global history)
//   otherwise. One prediction request and one resolved-branch update per cycle;
//   predictions return one rdy cycle later as a registered valid pulse.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes all state and outputs
//   clear_flag_in       flush; drops the request presented in the same cycle
//   ready_out           high once the init sweep has filled the table
//   pred_valid_in       prediction request, PC on pred_pc_in
//   pred_valid_out      result pulse with pred_taken_out / pred_index_out
//   upd_valid_in        resolved-branch update at upd_index_in
//   upd_taken_in        actual direction; upd_pred_in is the predicted one
//   mispredict_cnt_out  saturating count of updates where the two differ
module branch_predictor_table #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned HIST_BITS  = 0,
  parameter int unsigned INIT_CTR   = 2 ** (CTR_BITS - 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  clear_flag_in,
  output logic                  ready_out,
  input  logic                  pred_valid_in,
  input  logic [ADDR_WIDTH-1:0] pred_pc_in,
  output logic                  pred_valid_out,
  output logic                  pred_taken_out,
  output logic [INDEX_BITS-1:0] pred_index_out,
  input  logic                  upd_valid_in,
  input  logic [INDEX_BITS-1:0] upd_index_in,
  input  logic                  upd_taken_in,
  input  logic                  upd_pred_in,
  output logic [31:0]           mispredict_cnt_out
);

  localparam int unsigned Entries = 2 ** INDEX_BITS;
  // History register kept at least 1 bit wide so bimodal builds stay legal.
  localparam int unsigned GhrW = (HIST_BITS > 0) ? HIST_BITS : 1;
  localparam logic [CTR_BITS-1:0] CtrMax  = '1;
  localparam logic [CTR_BITS-1:0] CtrInit = CTR_BITS'(INIT_CTR);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] ptr_q, ptr_d;
  logic [GhrW-1:0]       ghr_q, ghr_d;
  logic [31:0]           mis_q, mis_d;
  logic                  pv_q, pv_d;
  logic                  pt_q, pt_d;
  logic [INDEX_BITS-1:0] pi_q, pi_d;

  logic [CTR_BITS-1:0]   table_q [Entries];

  logic                  tbl_we;
  logic [INDEX_BITS-1:0] tbl_waddr;
  logic [CTR_BITS-1:0]   tbl_wdata;

  logic [INDEX_BITS-1:0] pc_idx;
  logic [INDEX_BITS-1:0] ghr_ext;
  logic [INDEX_BITS-1:0] pred_idx;
  logic [CTR_BITS-1:0]   upd_cur;
  logic [CTR_BITS-1:0]   upd_new;
  logic [GhrW:0]         ghr_shift;
  logic                  unused_pc;

  // Only PC[INDEX_BITS+1:2] selects an entry; the rest is intentionally ignored.
  assign unused_pc = ^pred_pc_in;

  assign pc_idx   = pred_pc_in[INDEX_BITS+1:2];
  assign ghr_ext  = INDEX_BITS'(ghr_q);
  assign pred_idx = (HIST_BITS > 0) ? (pc_idx ^ ghr_ext) : pc_idx;

  // Saturating counter step for the update port.
  always_comb begin
    upd_cur = table_q[upd_index_in];
    upd_new = upd_cur;
    if (upd_taken_in) begin
      if (upd_cur != CtrMax) upd_new = upd_cur + 1'b1;
    end else begin
      if (upd_cur != '0) upd_new = upd_cur - 1'b1;
    end
  end

  assign ghr_shift = {ghr_q, upd_taken_in};

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ghr_d     = ghr_q;
    mis_d     = mis_q;
    pv_d      = pv_q;
    pt_d      = pt_q;
    pi_d      = pi_q;
    tbl_we    = 1'b0;
    tbl_waddr = '0;
    tbl_wdata = '0;

    if (rdy) begin
      unique case (state_q)
        StInit: begin
          tbl_we    = 1'b1;
          tbl_waddr = ptr_q;
          tbl_wdata = CtrInit;
          ptr_d     = ptr_q + 1'b1;
          pv_d      = 1'b0;
          if (ptr_q == '1) state_d = StRun;
        end
        StRun: begin
          // Read happens before this edge's update write: same-entry
          // hazards see the old counter and the pre-update history.
          pv_d = pred_valid_in && !clear_flag_in;
          if (pv_d) begin
            pt_d = table_q[pred_idx][CTR_BITS-1];
            pi_d = pred_idx;
          end
          if (upd_valid_in) begin
            tbl_we    = 1'b1;
            tbl_waddr = upd_index_in;
            tbl_wdata = upd_new;
            ghr_d     = (HIST_BITS > 0) ? ghr_shift[GhrW-1:0] : '0;
            if ((upd_taken_in != upd_pred_in) && (mis_q != '1)) begin
              mis_d = mis_q + 32'd1;
            end
          end
        end
        default: state_d = StInit;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      ptr_q   <= '0;
      ghr_q   <= '0;
      mis_q   <= '0;
      pv_q    <= 1'b0;
      pt_q    <= 1'b0;
      pi_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ghr_q   <= ghr_d;
      mis_q   <= mis_d;
      pv_q    <= pv_d;
      pt_q    <= pt_d;
      pi_q    <= pi_d;
    end
  end

  // Counter storage has no reset of its own; the init sweep fills it.
  always_ff @(posedge clk) begin
    if (!rst && tbl_we) table_q[tbl_waddr] <= tbl_wdata;
  end

  assign ready_out          = (state_q == StRun);
  assign pred_valid_out     = pv_q;
  assign pred_taken_out     = pt_q;
  assign pred_index_out     = pi_q;
  assign mispredict_cnt_out = mis_q;

endmodule
